// File: rtl/regfile_op_sequencer.sv
// Multi-cycle register-to-register ALU sequencer driving a 2**AW x DW register file's read/write ports.
// Optional REGFILE_SEQ_FLAGS_EN adds zero/carry status outputs flag_z and flag_c.
module regfile_op_sequencer #(
  parameter int DW = 8,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [2:0]    instr_op,
  input  logic [AW-1:0] instr_rd,
  input  logic [AW-1:0] instr_rs,
  input  logic [AW-1:0] instr_rt,
  input  logic [DW-1:0] instr_imm,
  output logic [AW-1:0] rf_raa,
  output logic          rf_rae,
  output logic [AW-1:0] rf_rba,
  output logic          rf_rbe,
  input  logic [DW-1:0] rf_porta,
  input  logic [DW-1:0] rf_portb,
  output logic [AW-1:0] rf_wa,
  output logic          rf_we,
  output logic [DW-1:0] rf_d,
  output logic          done,
  output logic [DW-1:0] result
`ifdef REGFILE_SEQ_FLAGS_EN
  ,
  output logic          flag_z,
  output logic          flag_c
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_EXEC  = 2'd2;
  localparam logic [1:0] S_WRITE = 2'd3;

  localparam logic [2:0] OP_NOP = 3'd0;
  localparam logic [2:0] OP_LDI = 3'd1;
  localparam logic [2:0] OP_MOV = 3'd2;
  localparam logic [2:0] OP_ADD = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_XOR = 3'd7;

  logic [1:0]    state;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q, rs_q, rt_q;
  logic [DW-1:0] a_q, b_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] result_q;
  logic          nop_done_q;
  logic [DW-1:0] alu_res;
  logic          read_phase;

`ifdef REGFILE_SEQ_FLAGS_EN
  logic alu_carry;
  logic carry_q;
  logic flag_z_q, flag_c_q;
`endif

  // NOTE: every variable assigned in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_res = '0;
`ifdef REGFILE_SEQ_FLAGS_EN
    alu_carry = 1'b0;
`endif
    case (op_q)
      OP_MOV: alu_res = a_q;
`ifdef REGFILE_SEQ_FLAGS_EN
      OP_ADD: {alu_carry, alu_res} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: begin
        alu_res   = a_q - b_q;
        alu_carry = (a_q < b_q);
      end
`else
      OP_ADD: alu_res = a_q + b_q;
      OP_SUB: alu_res = a_q - b_q;
`endif
      OP_AND: alu_res = a_q & b_q;
      OP_OR:  alu_res = a_q | b_q;
      OP_XOR: alu_res = a_q ^ b_q;
      default: alu_res = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      op_q       <= OP_NOP;
      rd_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      wdata_q    <= '0;
      result_q   <= '0;
      nop_done_q <= 1'b0;
`ifdef REGFILE_SEQ_FLAGS_EN
      carry_q    <= 1'b0;
      flag_z_q   <= 1'b0;
      flag_c_q   <= 1'b0;
`endif
    end else begin
      nop_done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            op_q    <= instr_op;
            rd_q    <= instr_rd;
            rs_q    <= instr_rs;
            rt_q    <= instr_rt;
            // LDI writes its immediate straight from here; ALU ops overwrite it in EXEC.
            wdata_q <= instr_imm;
`ifdef REGFILE_SEQ_FLAGS_EN
            carry_q <= 1'b0;
`endif
            if (instr_op == OP_NOP)      nop_done_q <= 1'b1;
            else if (instr_op == OP_LDI) state      <= S_WRITE;
            else                         state      <= S_READ;
          end
        end
        S_READ: begin
          a_q   <= rf_porta;
          b_q   <= rf_portb;
          state <= S_EXEC;
        end
        S_EXEC: begin
          wdata_q <= alu_res;
`ifdef REGFILE_SEQ_FLAGS_EN
          carry_q <= alu_carry;
`endif
          state   <= S_WRITE;
        end
        default: begin
          result_q <= wdata_q;
`ifdef REGFILE_SEQ_FLAGS_EN
          flag_z_q <= (wdata_q == '0);
          flag_c_q <= carry_q;
`endif
          state    <= S_IDLE;
        end
      endcase
    end
  end

  // Enables drop to 0 outside READ/EXEC so each READ presents a fresh rising edge to the file.
  assign read_phase  = (state == S_READ) || (state == S_EXEC);
  assign instr_ready = (state == S_IDLE);
  assign rf_rae      = read_phase;
  assign rf_rbe      = read_phase;
  assign rf_raa      = read_phase ? rs_q : '0;
  assign rf_rba      = read_phase ? rt_q : '0;
  assign rf_we       = (state == S_WRITE);
  assign rf_wa       = rf_we ? rd_q : '0;
  assign rf_d        = rf_we ? wdata_q : '0;
  assign done        = rf_we | nop_done_q;
  // The written value is visible on result in the WRITE cycle itself and held afterwards.
  assign result      = rf_we ? wdata_q : result_q;

`ifdef REGFILE_SEQ_FLAGS_EN
  assign flag_z = rf_we ? (wdata_q == '0) : flag_z_q;
  assign flag_c = rf_we ? carry_q : flag_c_q;
`endif

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Directed bench for regfile_op_sequencer with a behavioural 4x8 register file and a register scoreboard.
// Flag checks are compiled in when REGFILE_SEQ_FLAGS_EN is defined.
module tb_regfile_op_sequencer;

  localparam logic [2:0] NOP = 3'd0, LDI = 3'd1, MOV = 3'd2, ADD = 3'd3,
                         SUB = 3'd4, XOR = 3'd7;

  logic       clk = 1'b0;
  logic       rst;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_rd, instr_rs, instr_rt;
  logic [7:0] instr_imm;
  logic [1:0] rf_raa, rf_rba, rf_wa;
  logic       rf_rae, rf_rbe, rf_we;
  logic [7:0] rf_porta, rf_portb, rf_d;
  logic       done;
  logic [7:0] result;
`ifdef REGFILE_SEQ_FLAGS_EN
  logic       flag_z, flag_c;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] mem    [4];
  logic [7:0] exp_rf [4];

  always #5 clk = ~clk;

  regfile_op_sequencer #(.DW(8), .AW(2)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_op(instr_op), .instr_rd(instr_rd), .instr_rs(instr_rs),
    .instr_rt(instr_rt), .instr_imm(instr_imm),
    .rf_raa(rf_raa), .rf_rae(rf_rae), .rf_rba(rf_rba), .rf_rbe(rf_rbe),
    .rf_porta(rf_porta), .rf_portb(rf_portb),
    .rf_wa(rf_wa), .rf_we(rf_we), .rf_d(rf_d),
    .done(done), .result(result)
`ifdef REGFILE_SEQ_FLAGS_EN
    , .flag_z(flag_z), .flag_c(flag_c)
`endif
  );

  // Behavioural register file: write on the rising edge, combinational read.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= 8'h00;
    end else if (rf_we) begin
      mem[rf_wa] <= rf_d;
    end
  end
  assign rf_porta = rf_rae ? mem[rf_raa] : 8'h00;
  assign rf_portb = rf_rbe ? mem[rf_rba] : 8'h00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [1:0] rt, input logic [7:0] imm);
    instr_op  = op;
    instr_rd  = rd;
    instr_rs  = rs;
    instr_rt  = rt;
    instr_imm = imm;
    instr_valid = 1'b1;
  endtask

  // Issues one instruction and watches 6 cycles after the accept edge (accept edge = cycle 0).
  task automatic run_instr(input string name, input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] rs, input logic [1:0] rt, input logic [7:0] imm,
                           input int exp_we_cyc, input logic [7:0] exp_d,
                           input logic exp_z, input logic exp_c);
    int we_cnt, we_cyc, done_cnt, done_cyc;
    logic [1:0] wa_seen;
    logic [7:0] d_seen, res_seen;
    logic z_seen, c_seen;
    we_cnt = 0; we_cyc = 0; done_cnt = 0; done_cyc = 0;
    wa_seen = '0; d_seen = '0; res_seen = '0; z_seen = 1'b0; c_seen = 1'b0;
    @(negedge clk);
    check({name, " ready_idle"}, 32'(instr_ready), 32'd1);
    drive(op, rd, rs, rt, imm);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (n == 1) check({name, " ready_c1"}, 32'(instr_ready), 32'(op == NOP));
      if (rf_we) begin
        we_cnt++;
        we_cyc  = n;
        wa_seen = rf_wa;
        d_seen  = rf_d;
      end
      if (done) begin
        done_cnt++;
        done_cyc = n;
        res_seen = result;
`ifdef REGFILE_SEQ_FLAGS_EN
        z_seen = flag_z;
        c_seen = flag_c;
`endif
      end
    end
    check({name, " we_count"}, 32'(we_cnt), (exp_we_cyc != 0) ? 32'd1 : 32'd0);
    check({name, " done_count"}, 32'(done_cnt), 32'd1);
    check({name, " done_cycle"}, 32'(done_cyc), (exp_we_cyc != 0) ? 32'(exp_we_cyc) : 32'd1);
    if (exp_we_cyc != 0) begin
      check({name, " we_cycle"}, 32'(we_cyc), 32'(exp_we_cyc));
      check({name, " wa"}, 32'(wa_seen), 32'(rd));
      check({name, " wdata"}, 32'(d_seen), 32'(exp_d));
      check({name, " result"}, 32'(res_seen), 32'(exp_d));
      check({name, " result_held"}, 32'(result), 32'(exp_d));
      exp_rf[rd] = exp_d;
      check({name, " reg"}, 32'(mem[rd]), 32'(exp_d));
`ifdef REGFILE_SEQ_FLAGS_EN
      check({name, " flag_z"}, 32'(z_seen), 32'(exp_z));
      check({name, " flag_c"}, 32'(c_seen), 32'(exp_c));
`endif
    end
  endtask

  initial begin
    int we_cnt, done_cnt;
    rst = 1'b1;
    instr_valid = 1'b0;
    instr_op = NOP; instr_rd = '0; instr_rs = '0; instr_rt = '0; instr_imm = '0;
    for (int i = 0; i < 4; i++) exp_rf[i] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst ready", 32'(instr_ready), 32'd1);
    check("rst done", 32'(done), 32'd0);
    check("rst result", 32'(result), 32'd0);
    check("rst we", 32'(rf_we), 32'd0);
    check("rst rae", 32'(rf_rae), 32'd0);
    check("rst wa_d", {22'd0, rf_wa, rf_d}, 32'd0);
    rst = 1'b0;

    // T1: reset asserted for two cycles while an ADD sits in EXEC.
    @(negedge clk);
    drive(ADD, 2'd2, 2'd0, 2'd1, 8'h00);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(negedge clk);
    check("t1 rae_read", 32'(rf_rae), 32'd1);
    @(negedge clk);
    check("t1 rbe_exec", 32'(rf_rbe), 32'd1);
    rst = 1'b1;
    we_cnt = 0; done_cnt = 0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (n == 1) rst = 1'b0;
      if (rf_we) we_cnt++;
      if (done) done_cnt++;
    end
    check("t1 we_never", 32'(we_cnt), 32'd0);
    check("t1 done_never", 32'(done_cnt), 32'd0);
    check("t1 ready", 32'(instr_ready), 32'd1);
    check("t1 result", 32'(result), 32'd0);

    // T2: loads and a wrapping ADD.
    run_instr("t2 ldi r0", LDI, 2'd0, 2'd0, 2'd0, 8'h0F, 1, 8'h0F, 1'b0, 1'b0);
    run_instr("t2 ldi r1", LDI, 2'd1, 2'd0, 2'd0, 8'hF3, 1, 8'hF3, 1'b0, 1'b0);
    run_instr("t2 add",    ADD, 2'd2, 2'd0, 2'd1, 8'h00, 3, 8'h02, 1'b0, 1'b1);
    // T3: SUB with borrow.
    run_instr("t3 sub",    SUB, 2'd3, 2'd0, 2'd1, 8'h00, 3, 8'h1C, 1'b0, 1'b1);
    // T4: XOR with rd == rs == rt.
    run_instr("t4 xor",    XOR, 2'd1, 2'd1, 2'd1, 8'h00, 3, 8'h00, 1'b1, 1'b0);

    // T5: NOP with valid held; the next instruction is accepted in cycle 1.
    @(negedge clk);
    check("t5 ready_idle", 32'(instr_ready), 32'd1);
    drive(NOP, 2'd0, 2'd0, 2'd0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    check("t5 nop_done", 32'(done), 32'd1);
    check("t5 nop_we", 32'(rf_we), 32'd0);
    check("t5 ready_c1", 32'(instr_ready), 32'd1);
    drive(LDI, 2'd3, 2'd0, 2'd0, 8'h5A);
    @(posedge clk);
    #1 instr_valid = 1'b0;
    we_cnt = 0; done_cnt = 0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      if (n == 1) begin
        check("t5 ldi_we_c1", 32'(rf_we), 32'd1);
        check("t5 ldi_d", 32'(rf_d), 32'h5A);
      end
      if (rf_we) we_cnt++;
      if (done) done_cnt++;
    end
    check("t5 we_once", 32'(we_cnt), 32'd1);
    check("t5 done_once", 32'(done_cnt), 32'd1);
    exp_rf[3] = 8'h5A;
    check("t5 r3", 32'(mem[3]), 32'h5A);

    // T6: dependent chain through r1.
    run_instr("t6 ldi r0", LDI, 2'd0, 2'd0, 2'd0, 8'h40, 1, 8'h40, 1'b0, 1'b0);
    run_instr("t6 mov",    MOV, 2'd1, 2'd0, 2'd2, 8'h00, 3, 8'h40, 1'b0, 1'b0);
    run_instr("t6 add",    ADD, 2'd2, 2'd1, 2'd1, 8'h00, 3, 8'h80, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) check($sformatf("final r%0d", i), 32'(mem[i]), 32'(exp_rf[i]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
